// File: rtl/simple_threshold_ctrl_pkg.sv
// rtl/simple_threshold_ctrl_pkg.sv - shared state encoding and defaults for the simple_threshold run controller
package simple_threshold_ctrl_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_FLUSH = 3'd3;
   localparam logic [2:0] ST_HALT  = 3'd4;

   localparam int RST_CYCLES_DEFAULT = 4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_START = ST_START,
      S_RUN   = ST_RUN,
      S_FLUSH = ST_FLUSH,
      S_HALT  = ST_HALT
   } ctrl_state_t;

endpackage

// File: rtl/simple_threshold_dl_watchdog.sv
// rtl/simple_threshold_dl_watchdog.sv - block persistence counter, trip compare and deadlock capture
module simple_threshold_dl_watchdog #(
   parameter int NUM_AXIS = 7,
   parameter int DL_WIDTH = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                active,
   input  logic                suppress,
   input  logic                block,
   input  logic [DL_WIDTH-1:0] cfg_dl_limit,
   input  logic [NUM_AXIS-1:0] axis_block_sigs,
   input  logic                err_clear,
   output logic                trip,
   output logic                dl_flag,
   output logic [NUM_AXIS-1:0] dl_snapshot,
   output logic [7:0]          dl_count
);

   localparam logic [DL_WIDTH-1:0] ONE = DL_WIDTH'(1);

   logic [DL_WIDTH-1:0] wd_cnt;
   logic [DL_WIDTH-1:0] limit_m1;
   logic                limit_hit;

   // >= rather than == so a limit lowered below the running count trips at once
   always_comb begin
      limit_m1  = cfg_dl_limit - ONE;
      limit_hit = (cfg_dl_limit != '0) && (wd_cnt >= limit_m1);
      trip      = active && block && !suppress && limit_hit;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wd_cnt <= '0;
      end else if (!active || !block) begin
         wd_cnt <= '0;
      end else if (wd_cnt != '1) begin
         wd_cnt <= wd_cnt + ONE;
      end
   end

   // A trip outranks a coincident err_clear so the event is never lost
   always_ff @(posedge clock) begin
      if (reset) begin
         dl_flag     <= 1'b0;
         dl_snapshot <= '0;
         dl_count    <= 8'd0;
      end else begin
         if (trip) begin
            dl_flag     <= 1'b1;
            dl_snapshot <= axis_block_sigs;
         end else if (err_clear) begin
            dl_flag     <= 1'b0;
            dl_snapshot <= '0;
         end
         if (trip && (dl_count != 8'hFF)) begin
            dl_count <= dl_count + 8'd1;
         end
      end
   end

endmodule

// File: rtl/simple_threshold_run_ctrl.sv
// rtl/simple_threshold_run_ctrl.sv - ap_ctrl_hs run controller with deadlock watchdog and kernel flush
module simple_threshold_run_ctrl
   import simple_threshold_ctrl_pkg::*;
#(
   parameter int NUM_AXIS   = 7,
   parameter int DL_WIDTH   = 16,
   parameter int RST_CYCLES = RST_CYCLES_DEFAULT
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cfg_enable,
   input  logic                cfg_auto_restart,
   input  logic [DL_WIDTH-1:0] cfg_dl_limit,
   input  logic                err_clear,
   output logic                ap_start,
   input  logic                ap_ready,
   input  logic                ap_done,
   input  logic                ap_idle,
   input  logic                block,
   input  logic [NUM_AXIS-1:0] axis_block_sigs,
   output logic                kern_reset,
   output logic                dl_flag,
   output logic [NUM_AXIS-1:0] dl_snapshot,
   output logic [7:0]          dl_count,
   output logic [31:0]         run_count,
   output logic [2:0]          state_o
);

   localparam logic [7:0] FLUSH_LOAD = 8'(RST_CYCLES - 1);

   ctrl_state_t state;
   ctrl_state_t state_next;
   logic [7:0]  flush_cnt;
   logic        wd_active;
   logic        done_wins;
   logic        trip;

   assign wd_active = (state == S_START) || (state == S_RUN);
   assign done_wins = (state == S_RUN) && ap_done;

   simple_threshold_dl_watchdog #(
      .NUM_AXIS (NUM_AXIS),
      .DL_WIDTH (DL_WIDTH)
   ) u_watchdog (
      .clock           (clock),
      .reset           (reset),
      .active          (wd_active),
      .suppress        (done_wins),
      .block           (block),
      .cfg_dl_limit    (cfg_dl_limit),
      .axis_block_sigs (axis_block_sigs),
      .err_clear       (err_clear),
      .trip            (trip),
      .dl_flag         (dl_flag),
      .dl_snapshot     (dl_snapshot),
      .dl_count        (dl_count)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         flush_cnt <= 8'd0;
         run_count <= 32'd0;
      end else begin
         state <= state_next;
         if (trip) begin
            flush_cnt <= FLUSH_LOAD;
         end else if ((state == S_FLUSH) && (flush_cnt != 8'd0)) begin
            flush_cnt <= flush_cnt - 8'd1;
         end
         if (done_wins) begin
            run_count <= run_count + 32'd1;
         end
      end
   end

   // cfg_enable gates only new starts; an in-flight handshake or run always completes
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (cfg_enable && ap_idle) state_next = S_START;
         end
         S_START: begin
            if (trip)          state_next = S_FLUSH;
            else if (ap_ready) state_next = S_RUN;
         end
         S_RUN: begin
            if (ap_done)   state_next = S_IDLE;
            else if (trip) state_next = S_FLUSH;
         end
         S_FLUSH: begin
            if (flush_cnt == 8'd0) state_next = cfg_auto_restart ? S_IDLE : S_HALT;
         end
         S_HALT: begin
            if (err_clear) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign ap_start   = (state == S_START);
   assign kern_reset = (state == S_FLUSH);
   assign state_o    = state;

endmodule

// File: doc/simple_threshold_run_ctrl.md
# simple_threshold_run_ctrl

Run controller for the `simple_threshold` HLS kernel. It drives the kernel's `ap_ctrl_hs` handshake so the kernel is started back-to-back while enabled. It watches the deadlock monitor's `block` output with a programmable persistence watchdog. On a confirmed deadlock it captures which AXIS channel was blocked, pulses a kernel reset, and either auto-restarts or halts until software clears the error.

## Interface
Parameters:
- `NUM_AXIS`, 7: width of the AXIS block-signal vector from the monitor.
- `DL_WIDTH`, 16: width of the watchdog limit and counter.
- `RST_CYCLES`, 4: length of the kernel reset pulse in cycles; legal range 1..255.

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `cfg_enable`, in, 1: allow new kernel starts.
- `cfg_auto_restart`, in, 1: after a flush, return to IDLE instead of HALT.
- `cfg_dl_limit`, in, `DL_WIDTH`: number of consecutive `block` cycles that trips the watchdog; 0 disables it.
- `err_clear`, in, 1: single-cycle pulse; clears the error state.
- `ap_start`, out, 1: kernel start.
- `ap_ready`, in, 1: kernel ready.
- `ap_done`, in, 1: kernel done.
- `ap_idle`, in, 1: kernel idle.
- `block`, in, 1: deadlock monitor output.
- `axis_block_sigs`, in, `NUM_AXIS`: per-channel block vector, the same vector fed to the monitor.
- `kern_reset`, out, 1: active-high kernel reset.
- `dl_flag`, out, 1: sticky deadlock indicator.
- `dl_snapshot`, out, `NUM_AXIS`: `axis_block_sigs` captured at the trip cycle.
- `dl_count`, out, 8: saturating count of deadlock events.
- `run_count`, out, 32: completed runs; wraps at 2^32.
- `state_o`, out, 3: current FSM state, for debug.

## Operation
FSM states are IDLE, START, RUN, FLUSH and HALT, with a registered state.
- **Output decode:** `ap_start` = (state==START); `kern_reset` = (state==FLUSH).
- **IDLE:** go to START when `cfg_enable` and `ap_idle` are both 1.
- **START:** hold `ap_start`. Go to RUN on the first cycle where `ap_ready` is 1.
- **RUN:** go to IDLE on `ap_done`, and increment `run_count` in that cycle.
- **Watchdog counter (`wd_cnt`):**
  - Counts only in START and RUN while `block` is 1.
  - Cleared whenever `block` is 0 or the state is IDLE, FLUSH or HALT.
  - Saturates at its maximum.
- **Watchdog trip:** occurs when `cfg_dl_limit` is nonzero, `block` is 1, and `wd_cnt == cfg_dl_limit-1`. On a trip:
  - next state is FLUSH;
  - `dl_snapshot` <= `axis_block_sigs`;
  - `dl_flag` <= 1;
  - `dl_count` increments, saturating at 255;
  - the flush counter loads `RST_CYCLES-1`.
- **FLUSH:** lasts exactly `RST_CYCLES` cycles. At the end, go to IDLE if `cfg_auto_restart` is 1, otherwise to HALT.
- **HALT:** `ap_start` stays 0. On `err_clear`, go to IDLE.
- **`err_clear` in any state:** `dl_flag` <= 0 and `dl_snapshot` <= 0. `dl_count` and `run_count` are not cleared.
- **Simultaneous-event priorities:**
  - `ap_done` and a trip in the same RUN cycle: `ap_done` wins. The run is counted, state goes to IDLE, and there is no trip.
  - `ap_ready` and a trip in START: the trip wins.
  - A trip and `err_clear` in the same cycle: the trip wins, so `dl_flag` ends at 1.
- **Disable:** deasserting `cfg_enable` in START or RUN does not abort. The current handshake and run complete, and no new start is issued.
- **`cfg_dl_limit` changes mid-run:** take effect immediately. Compare with `wd_cnt >= cfg_dl_limit-1` so that lowering the limit below the current count trips on the next `block` cycle.

## Timing
- **Reset values:** state IDLE; `ap_start` 0; `kern_reset` 0; `dl_flag` 0; `dl_snapshot` 0; `dl_count` 0; `run_count` 0; `wd_cnt` 0.
- **Start latency:** `cfg_enable` and `ap_idle` high at cycle t gives `ap_start` high at t+1.
- **Back-to-back runs:** `ap_done` at t gives IDLE at t+1 and `ap_start` at t+2, if still enabled and idle.
- **Trip timing:** with `block` continuously high from cycle t in RUN and limit L, the trip is evaluated at t+L-1. State is FLUSH from t+L, and `kern_reset` is high for cycles t+L .. t+L+RST_CYCLES-1.
- **Output registration:** `dl_flag`, `dl_snapshot` and `dl_count` update at the clock edge ending the trip cycle.
- **Reset mid-run:** `reset` mid-run returns all registers to reset values on the next edge. `kern_reset` is not asserted by a controller reset.

## Structure
- Shared package `simple_threshold_ctrl_pkg`: FSM state encoding (3-bit localparams) and the `RST_CYCLES` default.
- One sub-module: `simple_threshold_dl_watchdog`, containing the persistence counter, trip compare and snapshot capture. The FSM lives in the top.

## Test plan
- **Normal runs:** enable=1, kernel model with ready one cycle after start and done 10 cycles later, for 3 runs -> `run_count`=3, `ap_start` asserted 3 times, each 2 cycles after the previous `ap_done`.
- **Deadlock trip, auto-restart:** L=5, `block` high 5 cycles in RUN with `axis_block_sigs`=7'b0000100 -> FLUSH entered, `kern_reset` high 4 cycles, `dl_snapshot`=7'b0000100, `dl_flag`=1, `dl_count`=1, return to IDLE, then restart.
- **Deadlock trip, no auto-restart:** as above with `cfg_auto_restart`=0 -> HALT, no `ap_start`. Pulse `err_clear` -> `dl_flag`=0, snapshot=0, IDLE, start resumes.
- **Glitch filtering:** L=5, `block` high 4 cycles, low 1, high 4 -> no trip, `dl_count`=0.
- **Simultaneous `ap_done` and trip edge:** `ap_done` in the trip cycle -> `run_count` increments, no FLUSH. Also `err_clear` coincident with a trip -> `dl_flag`=1.
- **Watchdog disabled and mid-run disable:** `cfg_dl_limit`=0 with `block` high 1000 cycles -> no trip. Deassert enable mid-RUN -> run completes, no further `ap_start`.
